// File: rtl/pkt_rx_dequeue_if.sv
// MAC receive, output stream and statistics signals of the receive dequeue engine.
// The engine uses the slave view; the MAC/downstream environment uses the master view.
interface pkt_rx_dequeue_if;
  logic        pkt_rx_avail;
  logic        pkt_rx_ren;
  logic        pkt_rx_val;
  logic [63:0] pkt_rx_data;
  logic        pkt_rx_sop;
  logic        pkt_rx_eop;
  logic [2:0]  pkt_rx_mod;
  logic        pkt_rx_err;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic [2:0]  out_mod;
  logic        out_err;
  logic [15:0] out_len;
  logic [31:0] rx_pkt_count;
  logic [31:0] rx_err_count;
  logic [15:0] proto_err_count;

  modport slave (
    input  pkt_rx_avail, pkt_rx_val, pkt_rx_data, pkt_rx_sop, pkt_rx_eop,
           pkt_rx_mod, pkt_rx_err, out_ready,
    output pkt_rx_ren, out_valid, out_data, out_sop, out_eop, out_mod,
           out_err, out_len, rx_pkt_count, rx_err_count, proto_err_count
  );

  modport master (
    output pkt_rx_avail, pkt_rx_val, pkt_rx_data, pkt_rx_sop, pkt_rx_eop,
           pkt_rx_mod, pkt_rx_err, out_ready,
    input  pkt_rx_ren, out_valid, out_data, out_sop, out_eop, out_mod,
           out_err, out_len, rx_pkt_count, rx_err_count, proto_err_count
  );
endinterface

// File: rtl/pkt_rx_dequeue.sv
// Receive dequeue engine: paces MAC reads with FIFO credits, checks framing and
// length, and presents whole packets on a show-ahead valid/ready stream.
module pkt_rx_dequeue #(
  parameter int FIFO_DEPTH    = 4,
  parameter int MIN_PKT_BYTES = 64,
  parameter int MAX_PKT_BYTES = 9216
) (
  input  logic            clk_156m25,
  input  logic            reset_156m25_n,
  pkt_rx_dequeue_if.slave io_bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, READ, GAP} state_t;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic        err;
    logic [15:0] len;
  } entry_t;

  state_t        r_state;
  logic          r_ren;
  logic          r_in_pkt;
  logic [15:0]   r_acc;
  entry_t        r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_pkt_cnt;
  logic [31:0]   r_err_cnt;
  logic [15:0]   r_proto_cnt;

  logic          w_drop;
  logic          w_restart;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [3:0]    w_mod_bytes;
  logic [16:0]   w_base;
  logic [16:0]   w_sum;
  logic [15:0]   w_len_next;
  logic          w_len_err;
  entry_t        w_entry;
  logic [CW-1:0] w_count_next;
  logic          w_credit_ok;

  // One adder serves both the running count (non-eop) and the final length (eop).
  always_comb begin
    w_drop       = io_bus.pkt_rx_val && !io_bus.pkt_rx_sop && !r_in_pkt;
    w_restart    = io_bus.pkt_rx_val && io_bus.pkt_rx_sop && r_in_pkt;
    w_full       = (r_count == CW'(FIFO_DEPTH));
    w_push       = io_bus.pkt_rx_val && !w_drop && !w_full;
    w_pop        = (r_count != '0) && io_bus.out_ready;
    w_mod_bytes  = (io_bus.pkt_rx_mod == 3'd0) ? 4'd8 : {1'b0, io_bus.pkt_rx_mod};
    w_base       = io_bus.pkt_rx_sop ? 17'd0 : {1'b0, r_acc};
    w_sum        = w_base + (io_bus.pkt_rx_eop ? {13'd0, w_mod_bytes} : 17'd8);
    w_len_next   = w_sum[16] ? 16'hFFFF : w_sum[15:0];
    w_len_err    = ({16'd0, w_len_next} < 32'(MIN_PKT_BYTES)) ||
                   ({16'd0, w_len_next} > 32'(MAX_PKT_BYTES));
    w_entry.data = io_bus.pkt_rx_data;
    w_entry.sop  = io_bus.pkt_rx_sop;
    w_entry.eop  = io_bus.pkt_rx_eop;
    w_entry.mod  = io_bus.pkt_rx_mod;
    w_entry.err  = io_bus.pkt_rx_eop && (io_bus.pkt_rx_err || w_len_err);
    w_entry.len  = io_bus.pkt_rx_eop ? w_len_next : 16'd0;
    w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    w_credit_ok  = (w_count_next + CW'(r_ren)) <= CW'(FIFO_DEPTH - 2);
  end

  // A waiting packet on leaving GAP re-enters READ directly so back-to-back
  // packets see only a single idle read cycle.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      r_state <= IDLE;
      r_ren   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ren <= 1'b0;
          if (io_bus.pkt_rx_avail) begin
            r_state <= READ;
            r_ren   <= w_credit_ok;
          end
        end
        READ: begin
          if (io_bus.pkt_rx_val && io_bus.pkt_rx_eop) begin
            r_state <= GAP;
            r_ren   <= 1'b0;
          end else begin
            r_ren <= w_credit_ok;
          end
        end
        GAP: begin
          if (io_bus.pkt_rx_avail) begin
            r_state <= READ;
            r_ren   <= w_credit_ok;
          end else begin
            r_state <= IDLE;
            r_ren   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ren   <= 1'b0;
        end
      endcase
    end
  end

  // Statistics count at push time so they track the MAC, not the consumer.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_in_pkt    <= 1'b0;
      r_acc       <= 16'd0;
      r_pkt_cnt   <= 32'd0;
      r_err_cnt   <= 32'd0;
      r_proto_cnt <= 16'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_entry;
        r_wptr        <= r_wptr + AW'(1);
        r_in_pkt      <= !io_bus.pkt_rx_eop;
        r_acc         <= io_bus.pkt_rx_eop ? 16'd0 : w_len_next;
        if (io_bus.pkt_rx_eop) begin
          r_pkt_cnt <= r_pkt_cnt + 32'd1;
          if (w_entry.err) r_err_cnt <= r_err_cnt + 32'd1;
        end
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_next;
      if (w_drop || w_restart) r_proto_cnt <= r_proto_cnt + 16'd1;
    end
  end

  assign io_bus.pkt_rx_ren      = r_ren;
  assign io_bus.out_valid       = (r_count != '0);
  assign io_bus.out_data        = r_mem[r_rptr].data;
  assign io_bus.out_sop         = r_mem[r_rptr].sop;
  assign io_bus.out_eop         = r_mem[r_rptr].eop;
  assign io_bus.out_mod         = r_mem[r_rptr].mod;
  assign io_bus.out_err         = r_mem[r_rptr].err;
  assign io_bus.out_len         = r_mem[r_rptr].len;
  assign io_bus.rx_pkt_count    = r_pkt_cnt;
  assign io_bus.rx_err_count    = r_err_cnt;
  assign io_bus.proto_err_count = r_proto_cnt;
endmodule

// File: tb/tb_pkt_rx_dequeue.sv
// Directed bench for pkt_rx_dequeue: a small MAC model answers reads one cycle
// late, and a scoreboard of hand-specified words is compared against the stream.
module tb_pkt_rx_dequeue;
  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic        err;
    logic        drop;
    logic [15:0] expLen;
    logic        expErr;
  } macWord_t;

  logic clk_156m25 = 1'b0;
  logic reset_156m25_n;

  int assertCount = 0;
  int failCount = 0;
  int cycle = 0;
  int readyMode = 0;
  int firstVal = -1;
  int firstOut = -1;
  int gapZeros = 0;
  logic macHold = 1'b0;
  logic renLast = 1'b0;
  logic curLegal = 1'b0;
  logic gapArm = 1'b0;
  logic gapOpen = 1'b0;
  macWord_t macQ[$];
  macWord_t rawQ[$];
  macWord_t expQ[$];

  pkt_rx_dequeue_if bus();

  pkt_rx_dequeue #(
    .FIFO_DEPTH(4),
    .MIN_PKT_BYTES(64),
    .MAX_PKT_BYTES(9216)
  ) dut (
    .clk_156m25(clk_156m25),
    .reset_156m25_n(reset_156m25_n),
    .io_bus(bus)
  );

  always #5 clk_156m25 = ~clk_156m25;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  // Queue one MAC packet; the eop word carries the hand-computed length and error.
  task automatic applyStimulus(input logic [7:0] id, input int nBytes, input logic rxErr,
                               input logic [15:0] expLen, input logic expErr);
    int nWords;
    nWords = (nBytes + 7) / 8;
    for (int i = 0; i < nWords; i++) begin
      macWord_t w;
      w.data   = {id, 24'h5A5A00, 32'(i)};
      w.sop    = (i == 0);
      w.eop    = (i == nWords - 1);
      w.mod    = w.eop ? 3'(nBytes % 8) : 3'd0;
      w.err    = w.eop ? rxErr : 1'b0;
      w.drop   = 1'b0;
      w.expLen = w.eop ? expLen : 16'd0;
      w.expErr = w.eop ? expErr : 1'b0;
      macQ.push_back(w);
    end
  endtask

  task automatic addRawWord(input logic [63:0] data, input logic sop, input logic eop,
                            input logic drop, input logic [15:0] expLen, input logic expErr);
    macWord_t w;
    w.data   = data;
    w.sop    = sop;
    w.eop    = eop;
    w.mod    = 3'd0;
    w.err    = 1'b0;
    w.drop   = drop;
    w.expLen = expLen;
    w.expErr = expErr;
    rawQ.push_back(w);
  endtask

  task automatic driveWord(input macWord_t w);
    bus.pkt_rx_val  = 1'b1;
    bus.pkt_rx_data = w.data;
    bus.pkt_rx_sop  = w.sop;
    bus.pkt_rx_eop  = w.eop;
    bus.pkt_rx_mod  = w.mod;
    bus.pkt_rx_err  = w.err;
  endtask

  task automatic driveIdle();
    bus.pkt_rx_val  = 1'b0;
    bus.pkt_rx_data = 64'd0;
    bus.pkt_rx_sop  = 1'b0;
    bus.pkt_rx_eop  = 1'b0;
    bus.pkt_rx_mod  = 3'd0;
    bus.pkt_rx_err  = 1'b0;
  endtask

  // MAC answers last cycle's read; reads after an eop return nothing until ren drops.
  task automatic driveMac();
    macWord_t w;
    curLegal = 1'b0;
    driveIdle();
    if (!renLast) macHold = 1'b0;
    if (rawQ.size() != 0) begin
      w = rawQ.pop_front();
      driveWord(w);
      if (!w.drop) begin
        expQ.push_back(w);
        curLegal = 1'b1;
      end
    end else if (renLast && !macHold && macQ.size() != 0) begin
      w = macQ.pop_front();
      driveWord(w);
      expQ.push_back(w);
      curLegal = 1'b1;
      gapOpen = 1'b0;
      if (w.eop) begin
        macHold = 1'b1;
        if (gapArm) begin
          gapOpen = 1'b1;
          gapArm = 1'b0;
        end
      end
    end
    bus.pkt_rx_avail = (macQ.size() != 0);
    bus.out_ready = (readyMode == 0) ? 1'b1 : (readyMode == 1) ? (cycle % 3 == 0) : 1'b0;
  endtask

  task automatic sampleCheck();
    macWord_t w;
    int occ;
    int inFlight;
    occ = expQ.size() - int'(curLegal);
    inFlight = occ + int'(renLast);
    checkOutput("creditBound", 64'(inFlight <= 4), 64'd1);
    if (inFlight > 2) checkOutput("renLimit", 64'(bus.pkt_rx_ren), 64'd0);
    if (curLegal && firstVal < 0) firstVal = cycle;
    if (bus.out_valid && firstOut < 0) firstOut = cycle;
    if (gapOpen && !bus.pkt_rx_ren) gapZeros++;
    if (bus.out_valid && bus.out_ready) begin
      checkOutput("wordExpected", 64'(expQ.size() != 0), 64'd1);
      if (expQ.size() != 0) begin
        w = expQ.pop_front();
        checkOutput("outData", bus.out_data, w.data);
        checkOutput("outCtrl",
                    {42'd0, bus.out_sop, bus.out_eop, bus.out_mod, bus.out_err, bus.out_len},
                    {42'd0, w.sop, w.eop, w.mod, w.expErr, w.expLen});
      end
    end
    renLast = bus.pkt_rx_ren;
    cycle++;
  endtask

  task automatic tick();
    @(posedge clk_156m25);
    #1;
    driveMac();
    @(negedge clk_156m25);
    sampleCheck();
  endtask

  task automatic runUntilIdle(input int budget);
    int n;
    n = 0;
    while ((macQ.size() != 0 || rawQ.size() != 0 || expQ.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drainInBudget", 64'(n < budget), 64'd1);
    repeat (4) tick();
  endtask

  task automatic checkCounters(input int pkts, input int errs, input int protos);
    checkOutput("rxPktCount", 64'(bus.rx_pkt_count), 64'(pkts));
    checkOutput("rxErrCount", 64'(bus.rx_err_count), 64'(errs));
    checkOutput("protoErrCount", 64'(bus.proto_err_count), 64'(protos));
  endtask

  initial begin
    reset_156m25_n = 1'b0;
    driveIdle();
    bus.pkt_rx_avail = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checkOutput("rstRen", 64'(bus.pkt_rx_ren), 64'd0);
    checkOutput("rstValid", 64'(bus.out_valid), 64'd0);
    checkOutput("rstData", bus.out_data, 64'd0);
    checkOutput("rstLen", 64'(bus.out_len), 64'd0);
    checkCounters(0, 0, 0);
    repeat (2) @(posedge clk_156m25);
    @(negedge clk_156m25);
    reset_156m25_n = 1'b1;

    // 64-byte packet: read starts one cycle after avail, words one cycle after val
    applyStimulus(8'h01, 64, 1'b0, 16'd64, 1'b0);
    tick();
    checkOutput("renBeforeLatency", 64'(bus.pkt_rx_ren), 64'd0);
    tick();
    checkOutput("renAfterAvail", 64'(bus.pkt_rx_ren), 64'd1);
    runUntilIdle(200);
    checkOutput("outLatency", 64'(firstOut - firstVal), 64'd1);
    checkCounters(1, 0, 0);

    // Runt and oversize packets
    applyStimulus(8'h02, 61, 1'b0, 16'd61, 1'b1);
    runUntilIdle(200);
    checkCounters(2, 1, 0);
    applyStimulus(8'h03, 9217, 1'b0, 16'd9217, 1'b1);
    runUntilIdle(3000);
    checkCounters(3, 2, 0);

    // 1518-byte packet against a consumer ready one cycle in three
    readyMode = 1;
    applyStimulus(8'h04, 1518, 1'b0, 16'd1518, 1'b0);
    runUntilIdle(2000);
    readyMode = 0;
    checkCounters(4, 2, 0);

    // Stray word while idle is dropped; sop inside a packet restarts it
    addRawWord(64'hBAD0_0000_0000_0001, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0);
    addRawWord(64'h0B00_0000_0000_0002, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    addRawWord(64'h0C00_0000_0000_0003, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    addRawWord(64'h0D00_0000_0000_0004, 1'b0, 1'b1, 1'b0, 16'd16, 1'b1);
    runUntilIdle(50);
    checkCounters(5, 3, 2);

    // MAC error on a 128-byte packet, followed back-to-back by a good packet
    gapArm = 1'b1;
    gapZeros = 0;
    applyStimulus(8'h05, 128, 1'b1, 16'd128, 1'b1);
    applyStimulus(8'h06, 64, 1'b0, 16'd64, 1'b0);
    runUntilIdle(300);
    checkOutput("gapCycles", 64'(gapZeros), 64'd1);
    checkCounters(7, 4, 2);

    // Reset in the middle of a packet held back by a stalled consumer
    readyMode = 2;
    applyStimulus(8'h07, 64, 1'b0, 16'd64, 1'b0);
    repeat (6) tick();
    checkOutput("preResetValid", 64'(bus.out_valid), 64'd1);
    #2;
    reset_156m25_n = 1'b0;
    #1;
    checkOutput("asyncRstRen", 64'(bus.pkt_rx_ren), 64'd0);
    checkOutput("asyncRstValid", 64'(bus.out_valid), 64'd0);
    checkCounters(0, 0, 0);
    macQ.delete();
    rawQ.delete();
    expQ.delete();
    macHold = 1'b0;
    renLast = 1'b0;
    curLegal = 1'b0;
    driveIdle();
    bus.pkt_rx_avail = 1'b0;
    readyMode = 0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk_156m25);
    @(negedge clk_156m25);
    reset_156m25_n = 1'b1;
    applyStimulus(8'h08, 64, 1'b0, 16'd64, 1'b0);
    runUntilIdle(200);
    checkCounters(1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
